gpio_access_sched20: RTL and testbench

Round-robin scheduler that shares one GPIO pin bank (pin out, active-low output enable, pin in) between NUM_REQ requesters on the APB clock domain of the GPIO cluster.
Grants one requester exclusive drive of the bank at a time. Enforces a bounded hold time when others are waiting, and a tri-stated turnaround gap between owners.
Also provides a 2-flop synchronised copy of the pin inputs to all requesters.

---
 rtl/gpio_access_sched20_if.sv | 34 +++
 rtl/gpio_access_sched20.sv | 169 ++++++++++++++++
 tb/tb_gpio_access_sched20.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_access_sched20_if.sv
// Interface for the GPIO bank scheduler. It carries the requester-side
// request/grant bundle and the pin-bank connections.
// master: the requesters and the pin bank (the environment).
// slave : the scheduler.
interface gpio_access_sched20_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_pin_out;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_n_oe;
    logic [NUM_REQ-1:0]            gnt;
    logic [ID_W-1:0]               owner_id;
    logic                          busy;
    logic                          timeout_pulse;
    logic [DATA_WIDTH-1:0]         gpio_pin_out20;
    logic [DATA_WIDTH-1:0]         n_gpio_pin_oe20;
    logic [DATA_WIDTH-1:0]         gpio_pin_in20;
    logic [DATA_WIDTH-1:0]         pin_in_sync;

    modport master (
        output req, req_pin_out, req_n_oe, gpio_pin_in20,
        input  gnt, owner_id, busy, timeout_pulse,
               gpio_pin_out20, n_gpio_pin_oe20, pin_in_sync
    );

    modport slave (
        input  req, req_pin_out, req_n_oe, gpio_pin_in20,
        output gnt, owner_id, busy, timeout_pulse,
               gpio_pin_out20, n_gpio_pin_oe20, pin_in_sync
    );
endinterface

// File: rtl/gpio_access_sched20.sv
// Round-robin owner scheduler for one shared GPIO pin bank.
// Exactly one requester drives the pins at a time. A contended owner is
// released after MAX_HOLD grant cycles. Between owners the pins stay
// tri-stated for TA_CYCLES cycles. The pin inputs are synchronised by two flops.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// S_IDLE       | no owner, pins tri-stated, arbitrate from rr_ptr
// S_GRANT      | one owner, pins follow its slices one cycle late
// S_TURNAROUND | no owner, pins tri-stated for TA_CYCLES cycles, requests ignored
module gpio_access_sched20 #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_HOLD   = 64,
    parameter int TA_CYCLES  = 1
) (
    input  logic                  pclk20,
    input  logic                  p_reset20,
    gpio_access_sched20_if.slave  bus
);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD);
    localparam int TA_W   = (TA_CYCLES > 1) ? $clog2(TA_CYCLES) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [TA_W-1:0]   TA_LAST   = TA_W'(TA_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_GRANT      = 2'd1,
        S_TURNAROUND = 2'd2
    } state_t;

    state_t                state_q;
    logic [NUM_REQ-1:0]    gnt_q;
    logic [ID_W-1:0]       owner_q;
    logic                  busy_q;
    logic                  timeout_q;
    logic [DATA_WIDTH-1:0] pin_out_q;
    logic [DATA_WIDTH-1:0] n_oe_q;
    logic [ID_W-1:0]       rr_ptr_q;
    logic [HOLD_W-1:0]     hold_cnt_q;
    logic [TA_W-1:0]       ta_cnt_q;
    logic [DATA_WIDTH-1:0] sync1_q;
    logic [DATA_WIDTH-1:0] sync2_q;

    logic [ID_W-1:0]       win_d;
    logic [ID_W-1:0]       rr_next_d;
    logic [DATA_WIDTH-1:0] owner_out_d;
    logic [DATA_WIDTH-1:0] owner_n_oe_d;
    logic                  owner_req_d;
    logic                  others_req_d;

    // Winner: the first set request found when scanning upward from rr_ptr, with wrap-around.
    always_comb begin
        logic            found;
        logic [ID_W-1:0] cand;
        win_d = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!found && bus.req[cand]) begin
                win_d = cand;
                found = 1'b1;
            end
        end
    end

    // Select the owner's pin slices and gather the request status used for release decisions.
    always_comb begin
        owner_out_d  = '0;
        owner_n_oe_d = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == owner_q) begin
                owner_out_d  = bus.req_pin_out[i*DATA_WIDTH +: DATA_WIDTH];
                owner_n_oe_d = bus.req_n_oe[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        owner_req_d  = bus.req[owner_q];
        others_req_d = |(bus.req & ~gnt_q);
        rr_next_d    = ID_W'((int'(owner_q) + 1) % NUM_REQ);
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge pclk20) begin
        if (p_reset20) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            pin_out_q  <= '0;
            n_oe_q     <= '1;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            ta_cnt_q   <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    pin_out_q <= '0;
                    n_oe_q    <= '1;
                    if (|bus.req) begin
                        state_q    <= S_GRANT;
                        gnt_q      <= NUM_REQ'(1) << win_d;
                        owner_q    <= win_d;
                        busy_q     <= 1'b1;
                        hold_cnt_q <= '0;
                    end
                end
                S_GRANT: begin
                    // An owner that drops its request takes priority over a timeout in the same cycle.
                    if (!owner_req_d ||
                        (hold_cnt_q == HOLD_LAST && others_req_d)) begin
                        state_q   <= S_TURNAROUND;
                        gnt_q     <= '0;
                        busy_q    <= 1'b0;
                        rr_ptr_q  <= rr_next_d;
                        ta_cnt_q  <= TA_LAST;
                        pin_out_q <= '0;
                        n_oe_q    <= '1;
                        timeout_q <= owner_req_d;
                    end else begin
                        pin_out_q <= owner_out_d;
                        n_oe_q    <= owner_n_oe_d;
                        if (hold_cnt_q != HOLD_LAST) begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                    end
                end
                S_TURNAROUND: begin
                    pin_out_q <= '0;
                    n_oe_q    <= '1;
                    if (ta_cnt_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        ta_cnt_q <= ta_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    gnt_q     <= '0;
                    busy_q    <= 1'b0;
                    pin_out_q <= '0;
                    n_oe_q    <= '1;
                end
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous pin inputs. It runs in every state.
    always_ff @(posedge pclk20) begin
        if (p_reset20) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.gpio_pin_in20;
            sync2_q <= sync1_q;
        end
    end

    assign bus.gnt             = gnt_q;
    assign bus.owner_id        = owner_q;
    assign bus.busy            = busy_q;
    assign bus.timeout_pulse   = timeout_q;
    assign bus.gpio_pin_out20  = pin_out_q;
    assign bus.n_gpio_pin_oe20 = n_oe_q;
    assign bus.pin_in_sync     = sync2_q;
endmodule

// File: tb/tb_gpio_access_sched20.sv
// Directed bench for gpio_access_sched20 with NUM_REQ=4, DATA_WIDTH=16,
// MAX_HOLD=8 and TA_CYCLES=1.
module tb_gpio_access_sched20;
    localparam int NR = 4;
    localparam int DW = 16;
    localparam int MH = 8;
    localparam int TA = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gpio_access_sched20_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus();

    gpio_access_sched20 #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_HOLD(MH), .TA_CYCLES(TA)
    ) dut (
        .pclk20   (clk),
        .p_reset20(rst),
        .bus      (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] exp_out [4] = '{16'h1111, 16'h2222, 16'hA5A5, 16'h4444};
    logic [15:0] exp_noe [4] = '{16'h0F0F, 16'h3300, 16'h00FF, 16'h0000};
    logic [1:0]  ord     [4] = '{2'd0, 2'd1, 2'd3, 2'd0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = '0;
        tick();
        rst = 1'b0;
    endtask

    // Returns the number of zero-grant samples before the next grant appears.
    task automatic wait_gnt(output int n);
        n = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (bus.gnt != '0) break;
            n++;
        end
        chk("gnt_seen", {31'b0, |bus.gnt}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;
        rst = 1'b1;
        bus.req = 4'b1111;
        bus.req_pin_out = {exp_out[3], exp_out[2], exp_out[1], exp_out[0]};
        bus.req_n_oe    = {exp_noe[3], exp_noe[2], exp_noe[1], exp_noe[0]};
        bus.gpio_pin_in20 = '0;

        // Reset held for two cycles while all four requesters are requesting.
        tick(); tick();
        chk("rst_gnt",  32'(bus.gnt), 32'h0);
        chk("rst_noe",  32'(bus.n_gpio_pin_oe20), 32'hFFFF);
        chk("rst_out",  32'(bus.gpio_pin_out20), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_sync", 32'(bus.pin_in_sync), 32'h0);
        rst = 1'b0;
        tick();
        chk("post_rst_gnt",   32'(bus.gnt), 32'h1);
        chk("post_rst_owner", 32'(bus.owner_id), 32'h0);
        chk("post_rst_busy",  32'(bus.busy), 32'h1);
        chk("first_cyc_noe",  32'(bus.n_gpio_pin_oe20), 32'hFFFF);
        tick();
        chk("own0_out", 32'(bus.gpio_pin_out20), 32'h1111);
        chk("own0_noe", 32'(bus.n_gpio_pin_oe20), 32'h0F0F);
        bus.req = 4'b1110;
        tick();
        chk("rel0_gnt",  32'(bus.gnt), 32'h0);
        chk("rel0_busy", 32'(bus.busy), 32'h0);
        chk("rel0_noe",  32'(bus.n_gpio_pin_oe20), 32'hFFFF);
        chk("rel0_out",  32'(bus.gpio_pin_out20), 32'h0);
        chk("rel0_tp",   32'(bus.timeout_pulse), 32'h0);
        tick();
        chk("ta0_gnt", 32'(bus.gnt), 32'h0);
        tick();
        chk("own1_gnt", 32'(bus.gnt), 32'h2);
        tick();
        chk("own1_out", 32'(bus.gpio_pin_out20), 32'h2222);
        // Reset in the middle of a grant: pins go to tri-state and rr_ptr returns to 0.
        rst = 1'b1;
        bus.req = 4'b1111;
        tick();
        chk("midrst_gnt",  32'(bus.gnt), 32'h0);
        chk("midrst_noe",  32'(bus.n_gpio_pin_oe20), 32'hFFFF);
        chk("midrst_out",  32'(bus.gpio_pin_out20), 32'h0);
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        chk("midrst_tp",   32'(bus.timeout_pulse), 32'h0);
        rst = 1'b0;
        tick();
        chk("midrst_rr_gnt",   32'(bus.gnt), 32'h1);
        chk("midrst_rr_owner", 32'(bus.owner_id), 32'h0);

        // Single requester 2.
        do_reset();
        bus.req = 4'b0100;
        tick();
        chk("single_gnt",   32'(bus.gnt), 32'h4);
        chk("single_owner", 32'(bus.owner_id), 32'h2);
        chk("single_noe0",  32'(bus.n_gpio_pin_oe20), 32'hFFFF);
        tick();
        chk("single_out", 32'(bus.gpio_pin_out20), 32'hA5A5);
        chk("single_noe", 32'(bus.n_gpio_pin_oe20), 32'h00FF);
        bus.req = 4'b0000;
        tick();
        chk("single_ta_noe", 32'(bus.n_gpio_pin_oe20), 32'hFFFF);
        chk("single_ta_out", 32'(bus.gpio_pin_out20), 32'h0);
        chk("single_ta_gnt", 32'(bus.gnt), 32'h0);
        tick();
        chk("single_idle_busy", 32'(bus.busy), 32'h0);
        chk("single_idle_noe",  32'(bus.n_gpio_pin_oe20), 32'hFFFF);

        // Synchroniser latency while in IDLE.
        bus.gpio_pin_in20 = 16'h1234;
        tick();
        chk("sync_idle_1cyc", 32'(bus.pin_in_sync), 32'h0);
        tick();
        chk("sync_idle_2cyc", 32'(bus.pin_in_sync), 32'h1234);

        // Round robin with req=1011; each owner holds the grant for 3 cycles.
        do_reset();
        bus.req = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(n);
            if (k > 0) chk("rr_gap", 32'(n + 1), 32'(TA + 1));
            chk("rr_gnt",    32'(bus.gnt), 32'(1) << ord[k]);
            chk("rr_owner",  32'(bus.owner_id), 32'(ord[k]));
            chk("rr_onehot", 32'($countones(bus.gnt)), 32'd1);
            tick();
            chk("rr_out", 32'(bus.gpio_pin_out20), 32'(exp_out[ord[k]]));
            chk("rr_noe", 32'(bus.n_gpio_pin_oe20), 32'(exp_noe[ord[k]]));
            tick();
            bus.req[ord[k]] = 1'b0;
            tick();
            chk("rr_rel", 32'(bus.gnt), 32'h0);
            bus.req[ord[k]] = 1'b1;
        end

        // Timeout: requester 0 holds; requester 1 arrives in grant cycle 2.
        do_reset();
        bus.req = 4'b0001;
        tick();
        chk("to_gnt0", 32'(bus.gnt), 32'h1);
        tick();
        bus.req = 4'b0011;
        chk("to_tp_c2", 32'(bus.timeout_pulse), 32'h0);
        for (int c = 3; c <= MH; c++) begin
            tick();
            chk("to_hold", 32'(bus.gnt), 32'h1);
            chk("to_tp_early", 32'(bus.timeout_pulse), 32'h0);
        end
        tick();
        chk("to_pulse",    32'(bus.timeout_pulse), 32'h1);
        chk("to_rel_gnt",  32'(bus.gnt), 32'h0);
        chk("to_rel_noe",  32'(bus.n_gpio_pin_oe20), 32'hFFFF);
        tick();
        chk("to_pulse_width", 32'(bus.timeout_pulse), 32'h0);
        chk("to_gap_gnt",     32'(bus.gnt), 32'h0);
        tick();
        chk("to_next_gnt", 32'(bus.gnt), 32'h2);

        // The owner drops its request in the same cycle the timeout would fire.
        do_reset();
        bus.req = 4'b0011;
        tick();
        chk("drop_gnt0", 32'(bus.gnt), 32'h1);
        for (int c = 2; c <= MH; c++) begin
            tick();
            chk("drop_hold", 32'(bus.gnt), 32'h1);
            chk("drop_tp_early", 32'(bus.timeout_pulse), 32'h0);
        end
        bus.req = 4'b0010;
        tick();
        chk("drop_rel",      32'(bus.gnt), 32'h0);
        chk("drop_no_pulse", 32'(bus.timeout_pulse), 32'h0);
        tick();
        chk("drop_no_pulse2", 32'(bus.timeout_pulse), 32'h0);
        tick();
        chk("drop_next_gnt", 32'(bus.gnt), 32'h2);

        // A sole requester keeps the grant; a late contender forces an immediate release.
        do_reset();
        bus.req = 4'b0100;
        tick();
        chk("sole_gnt", 32'(bus.gnt), 32'h4);
        tick(); tick();
        bus.gpio_pin_in20 = 16'hBEEF;
        tick();
        chk("sync_grant_1cyc", 32'(bus.pin_in_sync), 32'h1234);
        tick();
        chk("sync_grant_2cyc", 32'(bus.pin_in_sync), 32'hBEEF);
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (bus.gnt != 4'b0100 || bus.timeout_pulse || bus.n_gpio_pin_oe20 != 16'h00FF)
                bad++;
        end
        chk("sole_hold200", 32'(bad), 32'h0);
        bus.req = 4'b0101;
        tick();
        chk("late_rel_gnt",  32'(bus.gnt), 32'h0);
        chk("late_rel_tp",   32'(bus.timeout_pulse), 32'h1);
        chk("late_rel_busy", 32'(bus.busy), 32'h0);
        tick();
        tick();
        chk("late_next_gnt", 32'(bus.gnt), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
